// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing helpers for the iterative divider.
package div_pkg;

    typedef enum logic {IDLE, BUSY} div_state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // A spare top bit keeps the trial sign exact even if rem_in[WIDTH] were ever set.
    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {2'b00, divisor};
    assign q       = ~trial[WIDTH+1];
    assign rem_out = q ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative unsigned restoring divider, one quotient bit per cycle,
// fixed latency of WIDTH+1 cycles from accepted go to done.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy
);
    localparam int CNT_W = cnt_w(WIDTH);

    div_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   prem_nx;
    logic             qbit;
    logic             last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in (prem),
        .bit_in (dvd[WIDTH-1]),
        .divisor(dvs),
        .rem_out(prem_nx),
        .q      (qbit)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign busy = (state == BUSY);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? BUSY : IDLE;
            BUSY:    state_nx = last ? IDLE : BUSY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            prem      <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && go) begin
                dvd  <= left;
                dvs  <= right;
                prem <= '0;
                cnt  <= '0;
            end else if (state == BUSY) begin
                // Quotient bits enter at the LSB as dividend bits leave at the MSB.
                dvd  <= {dvd[WIDTH-2:0], qbit};
                prem <= prem_nx;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    quotient  <= {dvd[WIDTH-2:0], qbit};
                    remainder <= prem_nx[WIDTH-1:0];
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative unsigned restoring divider; one quotient bit per cycle.
- Sits downstream of the combinational arithmetic primitives. It consumes their results as dividend and divisor and returns quotient and remainder after a fixed latency.
- Fills the gap left by the combinational library, which has add, subtract and multiply but no divide.
- Fixed latency lets scheduled designs instantiate it without a handshake on the consumer side.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  start request; sampled on rising edge.
- left  input  WIDTH  dividend (unsigned); sampled with go.
- right  input  WIDTH  divisor (unsigned); sampled with go.
- quotient  output  WIDTH  registered quotient of last completed operation.
- remainder  output  WIDTH  registered remainder of last completed operation.
- done  output  1  single-cycle pulse when quotient/remainder update.
- busy  output  1  high while an operation is in flight; go is ignored while high.

Behaviour:
- Reset (async assert, any cycle): state=IDLE, busy=0, done=0, quotient=0, remainder=0, step counter=0, internal operand registers=0. An in-flight operation is discarded with no done pulse.
- States: IDLE, BUSY.
- IDLE with go=1 at cycle T:
  - latch left into the dividend shift register and right into the divisor register;
  - clear the partial remainder (WIDTH+1 bits) and counter;
  - next state BUSY.
- IDLE with go=0: hold; outputs keep their last values.
- BUSY, each of cycles T+1..T+WIDTH, one restoring step:
  - shift {partial remainder, dividend MSB} left by 1;
  - trial = shifted − {1'b0, divisor} at WIDTH+1 bits;
  - if trial is non-negative (MSB=0): partial remainder = trial, quotient bit=1; else keep shifted value, quotient bit=0;
  - quotient bits shift in LSB-first into the dividend register.
  - counter increments.
- When the counter reaches WIDTH−1 and its step completes (edge ending cycle T+WIDTH):
  - quotient and remainder output registers load the final values;
  - done=1 during cycle T+WIDTH+1;
  - state returns to IDLE.
- Timing summary:
  - busy=1 exactly during cycles T+1..T+WIDTH.
  - done=1 exactly during cycle T+WIDTH+1.
  - Total latency go→done = WIDTH+1 cycles.
- Back-to-back: go is accepted in the cycle done=1 (state is IDLE), giving one operation per WIDTH+1 cycles.
- go while busy=1: ignored. left/right are not sampled, there is no queueing, and the in-flight result is unaffected.
- Output hold: quotient/remainder change only at the done edge or reset. They are stable during a subsequent BUSY period.
- Divide by zero (right=0): no special-case logic. The required result is quotient = all ones, remainder = left, with normal latency and done pulse.
- Arithmetic: all unsigned; no overflow is possible (quotient ≤ left, remainder < right when right≠0).
- left/right may change freely after the go cycle; only the values at the accepting edge matter.

Decomposition:
- Shared package div_pkg:
  - state enum div_state_t {IDLE, BUSY};
  - function clog2-based counter width constant CNT_W = $clog2(WIDTH).
- One natural sub-module: div_step, a combinational single restoring step.
  - Inputs: partial remainder (WIDTH+1), next dividend bit, divisor (WIDTH).
  - Outputs: new partial remainder and quotient bit.
  - Built on the existing Sub primitive.
  - Allows later unrolling into a pipelined divider.
- div_iter holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, go with left=100, right=7 at cycle 0 → busy cycles 1..8, done=1 at cycle 9 only, quotient=14, remainder=2; outputs held at 14/2 for 20 idle cycles.
- WIDTH=8, left=200, right=0 → done at +9, quotient=255, remainder=200.
- WIDTH=8, left=255, right=1 → quotient=255, remainder=0; then left=3, right=9 issued in the done cycle → accepted, done 9 cycles later, quotient=0, remainder=3.
- WIDTH=8, go 50/5 at cycle 0, go 90/4 at cycles 3 and 6 → single done at cycle 9 with quotient=10, remainder=0; no second done.
- WIDTH=8, go 77/3 at cycle 0, reset pulsed at cycle 4 → immediately busy=0, quotient=0, remainder=0, no done within the next 12 cycles; new go 77/3 → quotient=25, remainder=2 at +9.
- WIDTH=32 random regression, 1000 ops (including right=0 and right>left) → every result matches the reference model (left/right, left%right; divide-by-zero rule as above), and every done falls exactly 33 cycles after its accepting go.
